hilo_div_unit: RTL and testbench
================================

// Module: hilo_div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for DIV/DIVU in EX. Fed by the EX-stage control word (div start, signed select).
//  Quotient goes to LO and remainder to HI, via the HILO write path.
//  busy_o goes to the hazard unit, which raises StallE while a division is in flight.
//  valid_o qualifies the single-cycle HILO write.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH
// PORTS
//  clk          in   1      pipeline clock
//  rst          in   1      synchronous, active-high reset
//  start_i      in   1      EX-stage DIV/DIVU issue pulse (already gated by ~StallE in EX control)
//  signed_i     in   1      1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//  cancel_i     in   1      FlushE; aborts any division in progress
//  dividend_i   in   WIDTH  rs value; sampled with start_i
//  divisor_i    in   WIDTH  rt value; sampled with start_i
//  busy_o       out  1      combinational; high while the EX stage must hold
//  valid_o      out  1      registered one-cycle pulse; results valid, HILO write enable
//  quotient_o   out  WIDTH  to LO; held until next completion
//  remainder_o  out  WIDTH  to HI; held until next completion
// BEHAVIOUR
//  - Reset: state=IDLE, busy_o=0, valid_o=0, quotient_o=0, remainder_o=0, count=0. rst mid-operation abandons the division.
//  - FSM: IDLE, RUN, FIX, DONE.
//    - IDLE --start_i & ~cancel_i--> RUN
//    - RUN --count==WIDTH-1--> FIX
//    - FIX --> DONE
//    - DONE --> IDLE, or --> RUN if start_i & ~cancel_i (back-to-back issue)
//  - Accept (IDLE or DONE with start_i): latch |dividend|, |divisor| (magnitude only when signed_i), sign_q = sa^sb, sign_r = sa. Clear the partial remainder; count=0.
//  - RUN, per cycle:
//    - {r,q} <<= 1; trial = r - divisor.
//    - If trial is non-negative (WIDTH+1-bit compare): r = trial, q[0] = 1; else q[0] = 0.
//    - count++.
//  - FIX: negate q if sign_q, negate r if sign_r (signed only); write quotient_o/remainder_o.
//  - DONE: valid_o=1 for exactly this cycle.
//  - Latency: start at cycle 0 -> valid_o at cycle WIDTH+2 (34 for WIDTH=32).
//  - busy_o = (IDLE|DONE) & start_i & ~cancel_i | RUN | FIX. busy_o is 0 in the valid_o cycle, so EX releases on the same edge HILO is written.
//  - start_i while RUN/FIX: ignored; the hazard unit guarantees this does not occur.
//  - cancel_i has priority over start_i and over all states:
//    - next state IDLE; no valid_o follows;
//    - quotient_o/remainder_o keep their previous values.
//  - cancel_i in the DONE cycle: valid_o still asserted this cycle (already registered); the state returns to IDLE.
//  - Overflow 0x80000000 / -1 (signed): quotient=0x80000000, remainder=0 (wraps naturally; no trap).
//  - All arithmetic is modulo 2^WIDTH except the WIDTH+1-bit trial subtract.
// CONFIGURATION
//  - HILO_DIV_ZERO_FAST_EN defined: divisor==0 at accept goes straight to DONE.
//    - valid_o at cycle 1; quotient=all ones, remainder=raw dividend_i, regardless of signed_i.
//  - HILO_DIV_ZERO_FAST_EN undefined: divisor 0 runs the full algorithm.
//    - Unsigned: quotient=all ones, remainder=dividend, valid at cycle WIDTH+2.
//    - Signed: the FIX stage sign correction is applied to those values.
// STRUCTURE
//  - Shared package div_pkg:
//    - state encoding localparams (IDLE/RUN/FIX/DONE, 2 bits);
//    - count width = $clog2(WIDTH);
//    - DIV/DIVU ALUControl encodings shared with the controller decode.
//  - One sub-module, div_sign_fix: combinational abs-in / conditional-negate-out. Instantiated twice, at operand latch and at FIX.
//  - Datapath registers and the FSM stay in hilo_div_unit.
// TESTING
//  1. DIVU 100/7, start at cycle 0 -> busy_o 1 over cycles 0..33; valid_o only at cycle 34; quotient=14, remainder=2.
//  2. DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
//  3. DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; no extra cycles.
//  4. DIVU 50/3, cancel_i at cycle 10 -> busy_o 0 at cycle 11, no valid_o, outputs unchanged.
//     Then DIVU 7/7 -> quotient=1, remainder=0 at start+34.
//  5. DIVU 0x1234/0:
//     - macro on: valid_o at cycle 1, quotient=0xFFFFFFFF, remainder=0x1234;
//     - macro off: the same values at cycle 34.
//  6. rst asserted at cycle 15 of RUN -> next cycle all outputs 0, state IDLE.
//     Back-to-back start in the DONE cycle -> second result valid 34 cycles later.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the HILO divider and the controller decode.
//   - FSM state encodings (2 bits)
//   - default operand width and iteration counter width
//   - DIV / DIVU ALUControl encodings
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] ALU_DIV  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1011;

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: combinational conditional two's-complement negate of a pair of
// values. Used as abs() on the operands at accept and as the sign restore on
// quotient/remainder in FIX.
//   a, b          : input values
//   neg_a, neg_b  : negate the matching value when set
//   fix_a, fix_b  : results
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             neg_a,
    input  logic             neg_b,
    output logic [WIDTH-1:0] fix_a,
    output logic [WIDTH-1:0] fix_b
);

    assign fix_a = neg_a ? (~a + 1'b1) : a;
    assign fix_b = neg_b ? (~b + 1'b1) : b;

endmodule

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Quotient goes to LO, remainder to HI; valid_o is the one-cycle HILO write.
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : issue pulse; signed_i/dividend_i/divisor_i sampled with it
//   cancel_i      : flush; aborts any division, suppresses the pending write
//   busy_o        : combinational EX hold request
//   valid_o       : registered one-cycle result strobe
//   quotient_o    : LO value, held until next completion
//   remainder_o   : HI value, held until next completion
// Optional feature macro: HILO_DIV_ZERO_FAST_EN -- a zero divisor at accept
// completes in one cycle with quotient = all ones, remainder = raw dividend.
module hilo_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             cancel_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_acc, quo_acc, dvs;
    logic             sign_q, sign_r;

    logic             accept;
    logic             zero_fast;
    logic [WIDTH-1:0] abs_dvd, abs_dvs;
    logic [WIDTH-1:0] fix_q, fix_r;
    logic [WIDTH:0]   r_ext, trial;

    assign accept = (state == S_IDLE || state == S_DONE) && start_i && !cancel_i;

`ifdef HILO_DIV_ZERO_FAST_EN
    assign zero_fast = (divisor_i == '0);
`else
    assign zero_fast = 1'b0;
`endif

    assign busy_o = accept || state == S_RUN || state == S_FIX;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs (
        .a     (dividend_i),
        .b     (divisor_i),
        .neg_a (signed_i & dividend_i[WIDTH-1]),
        .neg_b (signed_i & divisor_i[WIDTH-1]),
        .fix_a (abs_dvd),
        .fix_b (abs_dvs)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .a     (quo_acc),
        .b     (rem_acc),
        .neg_a (sign_q),
        .neg_b (sign_r),
        .fix_a (fix_q),
        .fix_b (fix_r)
    );

    // Shift the next dividend bit into the partial remainder; the extra top
    // bit of the trial subtract is the borrow that decides restore vs keep.
    assign r_ext = {rem_acc, quo_acc[WIDTH-1]};
    assign trial = r_ext - {1'b0, dvs};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = zero_fast ? S_DONE : S_RUN;
            S_RUN:   if (count == LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = accept ? (zero_fast ? S_DONE : S_RUN) : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (cancel_i) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            dvs         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            valid_o     <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
        end else begin
            state   <= state_nxt;
            valid_o <= (state_nxt == S_DONE);
            if (accept) begin
                rem_acc <= '0;
                quo_acc <= abs_dvd;
                dvs     <= abs_dvs;
                sign_q  <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                sign_r  <= signed_i & dividend_i[WIDTH-1];
                count   <= '0;
                if (zero_fast) begin
                    quotient_o  <= '1;
                    remainder_o <= dividend_i;
                end
            end else if (state == S_RUN) begin
                count <= count + 1'b1;
                if (!trial[WIDTH]) begin
                    rem_acc <= trial[WIDTH-1:0];
                    quo_acc <= {quo_acc[WIDTH-2:0], 1'b1};
                end else begin
                    rem_acc <= r_ext[WIDTH-1:0];
                    quo_acc <= {quo_acc[WIDTH-2:0], 1'b0};
                end
            end
            if (state == S_FIX && !cancel_i) begin
                quotient_o  <= fix_q;
                remainder_o <= fix_r;
            end
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
`timescale 1ns/1ps
module tb_hilo_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, signed_i, cancel_i;
    logic [31:0] dividend_i, divisor_i;
    logic        busy_o, valid_o;
    logic [31:0] quotient_o, remainder_o;

    int vectors = 0;
    int miscompares = 0;

`ifdef HILO_DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 34;
`endif

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .cancel_i    (cancel_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    always #5 clk = ~clk;

    // Issue one operation at cycle 0 and watch span cycles. Inputs change on
    // the falling edge; outputs are sampled 1ns later.
    task automatic run_op(input logic [31:0] dvd, input logic [31:0] dvs, input logic sgn,
                          input int lat, input int span,
                          output int first_v, output int nvalid, output int busy_bad,
                          output logic [31:0] q_at, output logic [31:0] r_at);
        first_v = -1; nvalid = 0; busy_bad = 0; q_at = '0; r_at = '0;
        for (int c = 0; c < span; c++) begin
            @(negedge clk);
            start_i = (c == 0); signed_i = sgn; dividend_i = dvd; divisor_i = dvs;
            #1;
            if (busy_o !== (c < lat)) busy_bad++;
            if (valid_o === 1'b1) begin
                nvalid++;
                if (first_v < 0) begin
                    first_v = c; q_at = quotient_o; r_at = remainder_o;
                end
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 0; signed_i = 0; cancel_i = 0; dividend_i = 0; divisor_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy_o, valid_o, quotient_o, remainder_o} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%b valid=%b q=%h r=%h, want all 0", busy_o, valid_o, quotient_o, remainder_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        int fv, nv, bb; logic [31:0] q, r;
        run_op(32'd100, 32'd7, 1'b0, 34, 40, fv, nv, bb, q, r);
        vectors++; if (fv !== 34) begin miscompares++; $display("FAIL divu_latency: got %0d want 34", fv); end
        vectors++; if (nv !== 1) begin miscompares++; $display("FAIL divu_valid_count: got %0d want 1", nv); end
        vectors++; if (bb !== 0) begin miscompares++; $display("FAIL divu_busy: %0d bad cycles want 0", bb); end
        vectors++; if (q !== 32'd14 || r !== 32'd2) begin miscompares++; $display("FAIL divu_100_7: q=%h r=%h want 0000000e 00000002", q, r); end
        run_op(32'hFFFFFFFF, 32'h10, 1'b0, 34, 36, fv, nv, bb, q, r);
        vectors++; if (fv !== 34 || q !== 32'h0FFFFFFF || r !== 32'hF) begin miscompares++; $display("FAIL divu_big: cyc=%0d q=%h r=%h want 34 0fffffff 0000000f", fv, q, r); end
    endtask

    task automatic test_signed();
        int fv, nv, bb; logic [31:0] q, r;
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 34, 36, fv, nv, bb, q, r);
        vectors++; if (fv !== 34 || q !== 32'hFFFFFFFD || r !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_neg7_2: cyc=%0d q=%h r=%h want 34 fffffffd ffffffff", fv, q, r); end
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, 34, 36, fv, nv, bb, q, r);
        vectors++; if (fv !== 34 || q !== 32'hFFFFFFFD || r !== 32'd1) begin miscompares++; $display("FAIL div_7_neg2: cyc=%0d q=%h r=%h want 34 fffffffd 00000001", fv, q, r); end
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 34, 36, fv, nv, bb, q, r);
        vectors++; if (fv !== 34 || bb !== 0 || q !== 32'h80000000 || r !== 32'd0) begin miscompares++; $display("FAIL div_overflow: cyc=%0d busybad=%0d q=%h r=%h want 34 0 80000000 00000000", fv, bb, q, r); end
    endtask

    // Expects the previous result to be the overflow case.
    task automatic test_cancel();
        int nv = 0, bb = 0, fv; logic [31:0] q, r;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            start_i = (c == 0); signed_i = 0; dividend_i = 32'd50; divisor_i = 32'd3;
            cancel_i = (c == 10);
            #1;
            if (busy_o !== (c <= 10)) bb++;
            if (valid_o === 1'b1) nv++;
        end
        cancel_i = 1'b0;
        vectors++; if (bb !== 0) begin miscompares++; $display("FAIL cancel_busy: %0d bad cycles want 0", bb); end
        vectors++; if (nv !== 0) begin miscompares++; $display("FAIL cancel_valid: %0d pulses want 0", nv); end
        vectors++; if (quotient_o !== 32'h80000000 || remainder_o !== 32'd0) begin miscompares++; $display("FAIL cancel_hold: q=%h r=%h want 80000000 00000000", quotient_o, remainder_o); end
        run_op(32'd7, 32'd7, 1'b0, 34, 36, fv, nv, bb, q, r);
        vectors++; if (fv !== 34 || q !== 32'd1 || r !== 32'd0) begin miscompares++; $display("FAIL after_cancel_7_7: cyc=%0d q=%h r=%h want 34 00000001 00000000", fv, q, r); end
    endtask

    task automatic test_div_zero();
        int fv, nv, bb; logic [31:0] q, r;
        run_op(32'h1234, 32'd0, 1'b0, ZLAT, 38, fv, nv, bb, q, r);
        vectors++; if (fv !== ZLAT || nv !== 1 || bb !== 0) begin miscompares++; $display("FAIL divu_zero_timing: cyc=%0d n=%0d busybad=%0d want %0d 1 0", fv, nv, bb, ZLAT); end
        vectors++; if (q !== 32'hFFFFFFFF || r !== 32'h1234) begin miscompares++; $display("FAIL divu_zero_value: q=%h r=%h want ffffffff 00001234", q, r); end
        run_op(32'hFFFFFFFB, 32'd0, 1'b1, ZLAT, 38, fv, nv, bb, q, r);
`ifdef HILO_DIV_ZERO_FAST_EN
        vectors++; if (fv !== ZLAT || q !== 32'hFFFFFFFF || r !== 32'hFFFFFFFB) begin miscompares++; $display("FAIL div_zero_signed: cyc=%0d q=%h r=%h want 1 ffffffff fffffffb", fv, q, r); end
`else
        vectors++; if (fv !== ZLAT || q !== 32'd1 || r !== 32'hFFFFFFFB) begin miscompares++; $display("FAIL div_zero_signed: cyc=%0d q=%h r=%h want 34 00000001 fffffffb", fv, q, r); end
`endif
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            start_i = (c == 0); signed_i = 0; dividend_i = 32'd100; divisor_i = 32'd7;
            rst = (c == 15);
        end
        start_i = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({busy_o, valid_o, quotient_o, remainder_o} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b valid=%b q=%h r=%h want all 0", busy_o, valid_o, quotient_o, remainder_o);
        end
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (valid_o === 1'b1 || busy_o === 1'b1) nv++;
        end
        vectors++; if (nv !== 0) begin miscompares++; $display("FAIL reset_mid_idle: %0d active cycles want 0", nv); end
    endtask

    task automatic test_back_to_back();
        int bb = 0, nv = 0, v1 = -1, v2 = -1;
        logic [31:0] q1 = '0, r1 = '0, q2 = '0, r2 = '0;
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            start_i = (c == 0 || c == 34); signed_i = 0;
            dividend_i = (c < 34) ? 32'd100 : 32'd1000;
            divisor_i  = (c < 34) ? 32'd7   : 32'd10;
            #1;
            if (busy_o !== (c < 68)) bb++;
            if (valid_o === 1'b1) begin
                nv++;
                if (v1 < 0) begin v1 = c; q1 = quotient_o; r1 = remainder_o; end
                else begin v2 = c; q2 = quotient_o; r2 = remainder_o; end
            end
        end
        start_i = 1'b0;
        vectors++; if (bb !== 0 || nv !== 2) begin miscompares++; $display("FAIL b2b_timing: busybad=%0d pulses=%0d want 0 2", bb, nv); end
        vectors++; if (v1 !== 34 || q1 !== 32'd14 || r1 !== 32'd2) begin miscompares++; $display("FAIL b2b_first: cyc=%0d q=%h r=%h want 34 0000000e 00000002", v1, q1, r1); end
        vectors++; if (v2 !== 68 || q2 !== 32'd100 || r2 !== 32'd0) begin miscompares++; $display("FAIL b2b_second: cyc=%0d q=%h r=%h want 68 00000064 00000000", v2, q2, r2); end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_cancel();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
